// File: rtl/alu_mac_pipe.sv
// -----------------------------------------------------------------------------
// alu_mac_pipe
//
// Three-stage multiply-accumulate pipeline computing a signed dot product per
// packet. Each accepted beat carries K operand pairs. The lane products are
// summed and accumulated, with saturation, until the last beat of a packet.
//
//   Stage 1 : K lane products, each 2*DW+1 bits signed. Each beat's sgn selects
//             sign- or zero-extension of its own operands.
//   Stage 2 : signed sum of the K products, 2*DW+1+log2(K) bits.
//   Stage 3 : saturating accumulate into ACC_W bits plus a saturating beat
//             count. A last-tagged beat publishes the result and clears the
//             packet state.
//
// Ports
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   input beat valid
//   in_ready   beat can be accepted (low only while a result is stalled)
//   matrix_in  K packed DW-bit operands, lane 0 in the MSBs
//   vector_in  K packed DW-bit operands, lane 0 in the MSBs
//   sgn        1 = operands of this beat are signed, 0 = unsigned
//   in_last    marks the final beat of a packet
//   out_valid  result valid, held until out_ready
//   out_ready  downstream accepts the result
//   acc_out    signed dot-product result of the packet
//   ovf        the accumulator saturated at least once in the packet
//   cnt_out    beats in the packet, saturating at 2^CNT_W-1
// -----------------------------------------------------------------------------
module alu_mac_pipe #(
    parameter int K     = 4,
    parameter int DW    = 8,
    parameter int ACC_W = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW*K-1:0]  matrix_in,
    input  logic [DW*K-1:0]  vector_in,
    input  logic             sgn,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             ovf,
    output logic [CNT_W-1:0] cnt_out
);

    localparam int PW = 2 * DW + 1;     // lane product width
    localparam int LK = $clog2(K);      // growth bits of the K-way sum
    localparam int SW = PW + LK;        // lane sum width

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // Widen one operand to the product width. The extra bit lets unsigned
    // operands stay positive in a signed multiply.
    function automatic logic signed [PW-1:0] ext_op(
        input logic [DW-1:0] op,
        input logic          is_signed
    );
        logic signed [PW-1:0] r;
        if (is_signed) begin
            r = PW'($signed(op));
        end else begin
            r = PW'(op);
        end
        return r;
    endfunction

    // Clamp an ACC_W+1 bit sum to the ACC_W signed range. The return value
    // is {saturated_flag, clamped_value}.
    function automatic logic [ACC_W:0] sat_acc(input logic signed [ACC_W:0] v);
        logic [ACC_W:0] r;
        if (v[ACC_W] != v[ACC_W-1]) begin
            if (v[ACC_W]) begin
                r = {1'b1, ACC_MIN};
            end else begin
                r = {1'b1, ACC_MAX};
            end
        end else begin
            r = {1'b0, v[ACC_W-1:0]};
        end
        return r;
    endfunction

    // Beat counter increment that sticks at all-ones.
    function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
        logic [CNT_W-1:0] r;
        if (&c) begin
            r = c;
        end else begin
            r = c + CNT_W'(1'b1);
        end
        return r;
    endfunction

    // ---------------------------------------------------------------- state
    logic                    stall_s;

    logic                    s1_valid_r;
    logic                    s1_last_r;
    logic signed [PW-1:0]    prod_s [K];
    logic signed [PW-1:0]    prod_r [K];

    logic                    s2_valid_r;
    logic                    s2_last_r;
    logic signed [SW-1:0]    sum_s;
    logic signed [SW-1:0]    sum_r;

    logic signed [ACC_W-1:0] acc_r;
    logic [CNT_W-1:0]        cnt_r;
    logic                    ovf_r;
    logic signed [ACC_W:0]   tot_s;
    logic [ACC_W:0]          sat_s;
    logic [CNT_W-1:0]        cnt_nxt_s;

    logic                    out_valid_r;
    logic [ACC_W-1:0]        acc_out_r;
    logic                    ovf_out_r;
    logic [CNT_W-1:0]        cnt_out_r;

    // A result waiting on downstream freezes the whole pipeline.
    assign stall_s   = out_valid_r && !out_ready;
    assign in_ready  = !stall_s;

    assign out_valid = out_valid_r;
    assign acc_out   = acc_out_r;
    assign ovf       = ovf_out_r;
    assign cnt_out   = cnt_out_r;

    // Stage 1 lane multipliers; lane 0 occupies the most significant slice.
    always_comb begin
        for (int i = 0; i < K; i++) begin
            prod_s[i] = ext_op(matrix_in[(K-1-i)*DW +: DW], sgn)
                      * ext_op(vector_in[(K-1-i)*DW +: DW], sgn);
        end
    end

    // Stage 1 registers: lane products and beat tags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_last_r  <= 1'b0;
            for (int i = 0; i < K; i++) begin
                prod_r[i] <= {PW{1'b0}};
            end
        end else if (!stall_s) begin
            s1_valid_r <= in_valid;
            s1_last_r  <= in_valid && in_last;
            if (in_valid) begin
                prod_r <= prod_s;
            end
        end
    end

    // Stage 2 reduction of the K products; synthesis balances this into a tree.
    always_comb begin
        sum_s = {SW{1'b0}};
        for (int i = 0; i < K; i++) begin
            sum_s = sum_s + SW'(prod_r[i]);
        end
    end

    // Stage 2 registers: lane sum and tags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_r <= 1'b0;
            s2_last_r  <= 1'b0;
            sum_r      <= {SW{1'b0}};
        end else if (!stall_s) begin
            s2_valid_r <= s1_valid_r;
            s2_last_r  <= s1_last_r;
            if (s1_valid_r) begin
                sum_r <= sum_s;
            end
        end
    end

    // Stage 3 next accumulator value, with one guard bit to detect overflow.
    always_comb begin
        tot_s     = (ACC_W+1)'(acc_r) + (ACC_W+1)'(sum_r);
        sat_s     = sat_acc(tot_s);
        cnt_nxt_s = cnt_sat_inc(cnt_r);
    end

    // Stage 3 accumulate and result publication. When not stalled, any
    // previous result has been taken, so out_valid follows whether a new
    // last beat completes at this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r       <= {ACC_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            ovf_r       <= 1'b0;
            out_valid_r <= 1'b0;
            acc_out_r   <= {ACC_W{1'b0}};
            ovf_out_r   <= 1'b0;
            cnt_out_r   <= {CNT_W{1'b0}};
        end else if (!stall_s) begin
            if (s2_valid_r && s2_last_r) begin
                acc_out_r   <= sat_s[ACC_W-1:0];
                ovf_out_r   <= ovf_r | sat_s[ACC_W];
                cnt_out_r   <= cnt_nxt_s;
                out_valid_r <= 1'b1;
                acc_r       <= {ACC_W{1'b0}};
                cnt_r       <= {CNT_W{1'b0}};
                ovf_r       <= 1'b0;
            end else if (s2_valid_r) begin
                acc_r       <= sat_s[ACC_W-1:0];
                cnt_r       <= cnt_nxt_s;
                ovf_r       <= ovf_r | sat_s[ACC_W];
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_mac_pipe.sv
// Testbench for alu_mac_pipe: one instance with default parameters and one
// with ACC_W=20 share the same stimulus. A packet-level arithmetic model
// predicts every result for both accumulator widths.
module tb_alu_mac_pipe;

    localparam int K = 4;
    localparam int DW = 8;
    localparam int CNT_W = 8;
    localparam int AW0 = 32;
    localparam int AW1 = 20;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid, in_ready, in_ready20;
    logic [K*DW-1:0]  matrix_in, vector_in;
    logic             sgn, in_last, out_ready;
    logic             out_valid, ovf, out_valid20, ovf20;
    logic [AW0-1:0]   acc_out;
    logic [AW1-1:0]   acc_out20;
    logic [CNT_W-1:0] cnt_out, cnt_out20;

    alu_mac_pipe #(.K(K), .DW(DW), .ACC_W(AW0), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .matrix_in(matrix_in), .vector_in(vector_in), .sgn(sgn), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .acc_out(acc_out),
        .ovf(ovf), .cnt_out(cnt_out));

    alu_mac_pipe #(.K(K), .DW(DW), .ACC_W(AW1), .CNT_W(CNT_W)) dut20 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready20),
        .matrix_in(matrix_in), .vector_in(vector_in), .sgn(sgn), .in_last(in_last),
        .out_valid(out_valid20), .out_ready(out_ready), .acc_out(acc_out20),
        .ovf(ovf20), .cnt_out(cnt_out20));

    always #5 clk = ~clk;

    typedef struct {
        logic [K*DW-1:0] m;
        logic [K*DW-1:0] v;
        bit              s;
        bit              last;
    } beat_t;

    typedef struct {
        longint acc;
        bit     ovf;
        int     cnt;
    } res_t;

    beat_t  beat_q[$];
    res_t   exp0[$], exp1[$], obs0[$], obs1[$];
    longint m_acc[2];
    bit     m_ovf[2];
    int     m_cnt;
    int     checks = 0;
    int     failures = 0;
    int     bubble_pct = 0;

    // Dot product of one beat in plain integer arithmetic.
    function automatic longint beat_sum(beat_t b);
        longint s = 0;
        for (int i = 0; i < K; i++) begin
            logic [DW-1:0] a, c;
            longint pa, pc;
            a  = b.m[(K-1-i)*DW +: DW];
            c  = b.v[(K-1-i)*DW +: DW];
            pa = b.s ? longint'($signed(a)) : longint'(a);
            pc = b.s ? longint'($signed(c)) : longint'(c);
            s  = s + pa * pc;
        end
        return s;
    endfunction

    // Packet-level model: clamp after every beat, publish on the last one.
    function automatic void model_beat(beat_t b);
        longint s, lim;
        res_t r;
        s = beat_sum(b);
        for (int w = 0; w < 2; w++) begin
            lim = longint'(1) << ((w == 0 ? AW0 : AW1) - 1);
            m_acc[w] = m_acc[w] + s;
            if (m_acc[w] > lim - 1) begin
                m_acc[w] = lim - 1;
                m_ovf[w] = 1'b1;
            end else if (m_acc[w] < -lim) begin
                m_acc[w] = -lim;
                m_ovf[w] = 1'b1;
            end
        end
        m_cnt = (m_cnt < (1 << CNT_W) - 1) ? m_cnt + 1 : m_cnt;
        if (b.last) begin
            r.acc = m_acc[0]; r.ovf = m_ovf[0]; r.cnt = m_cnt; exp0.push_back(r);
            r.acc = m_acc[1]; r.ovf = m_ovf[1]; r.cnt = m_cnt; exp1.push_back(r);
            m_acc[0] = 0; m_acc[1] = 0; m_ovf[0] = 1'b0; m_ovf[1] = 1'b0; m_cnt = 0;
        end
    endfunction

    function automatic void model_clear();
        m_acc[0] = 0; m_acc[1] = 0; m_ovf[0] = 1'b0; m_ovf[1] = 1'b0; m_cnt = 0;
        exp0.delete(); exp1.delete(); obs0.delete(); obs1.delete(); beat_q.delete();
    endfunction

    function automatic beat_t mk(logic [K*DW-1:0] m, logic [K*DW-1:0] v, bit s, bit last);
        beat_t b;
        b.m = m; b.v = v; b.s = s; b.last = last;
        return b;
    endfunction

    // One clock cycle: drive from the head of beat_q at the falling edge,
    // record handshakes just after, then advance past the next rising edge.
    task automatic tick();
        res_t r;
        beat_t b;
        if (beat_q.size() > 0 && $urandom_range(99) >= bubble_pct) begin
            b = beat_q[0];
            in_valid = 1'b1; matrix_in = b.m; vector_in = b.v; sgn = b.s; in_last = b.last;
        end else begin
            in_valid = 1'b0; matrix_in = $urandom; vector_in = $urandom;
            sgn = 1'($urandom); in_last = 1'($urandom);
        end
        #1;
        if (out_valid && out_ready) begin
            r.acc = longint'($signed(acc_out)); r.ovf = ovf; r.cnt = int'(cnt_out);
            obs0.push_back(r);
        end
        if (out_valid20 && out_ready) begin
            r.acc = longint'($signed(acc_out20)); r.ovf = ovf20; r.cnt = int'(cnt_out20);
            obs1.push_back(r);
        end
        if (in_valid && in_ready) begin
            b = beat_q.pop_front();
            model_beat(b);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Send everything queued, then let the pipeline empty; returns 0 on timeout.
    task automatic drain(input int budget, output bit ok);
        int n = 0;
        out_ready = 1'b1;
        while (beat_q.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        repeat (6) tick();
        ok = (beat_q.size() == 0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; out_ready = 1'b0; in_valid = 1'b1; in_last = 1'b1; sgn = 1'b1;
        matrix_in = 32'hFFFF_FFFF; vector_in = 32'hFFFF_FFFF;
        model_clear();
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got %0b want 0", out_valid); end
        checks++; if (acc_out !== 32'd0) begin failures++; $display("FAIL rst_acc_out got %0d want 0", acc_out); end
        checks++; if (cnt_out !== 8'd0) begin failures++; $display("FAIL rst_cnt_out got %0d want 0", cnt_out); end
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL rst_ovf got %0b want 0", ovf); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got %0b want 1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL post_rst_in_ready got %0b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL post_rst_out_valid got %0b want 0", out_valid); end
    endtask

    task automatic test_basic_latency();
        bit ok;
        res_t o;
        bubble_pct = 0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) beat_q.push_back(mk(32'h0101_0101, 32'h0202_0202, 1'b1, i == 2));
        repeat (3) tick();
        checks++; if (beat_q.size() != 0) begin failures++; $display("FAIL basic_accept left %0d want 0", beat_q.size()); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_lat_e0 out_valid got %0b want 0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_lat_e1 out_valid got %0b want 0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_lat_e2 out_valid got %0b want 1", out_valid); end
        checks++; if (acc_out !== 32'd24 || cnt_out !== 8'd3 || ovf !== 1'b0)
            begin failures++; $display("FAIL basic_result got acc=%0d cnt=%0d ovf=%0b want 24/3/0", acc_out, cnt_out, ovf); end
        drain(50, ok);
        checks++; if (obs0.size() != 1 || exp0.size() != 1) begin failures++; $display("FAIL basic_count got %0d want 1", obs0.size()); end
        else begin
            o = obs0.pop_front();
            checks++; if (o.acc != exp0[0].acc || o.cnt != exp0[0].cnt)
                begin failures++; $display("FAIL basic_model got %0d want %0d", o.acc, exp0[0].acc); end
        end
        model_clear();
    endtask

    task automatic test_operand_modes();
        bit ok;
        res_t o;
        longint want[4] = '{65536, 65536, 260100, 4};
        beat_q.push_back(mk(32'h8080_8080, 32'h8080_8080, 1'b1, 1'b1));
        beat_q.push_back(mk(32'h8080_8080, 32'h8080_8080, 1'b0, 1'b1));
        beat_q.push_back(mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1));
        beat_q.push_back(mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1));
        drain(50, ok);
        checks++; if (!ok || obs0.size() != 4 || obs1.size() != 4)
            begin failures++; $display("FAIL modes_count got %0d want 4", obs0.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                o = obs0.pop_front();
                checks++; if (o.acc != want[i] || o.cnt != 1 || o.ovf != 1'b0)
                    begin failures++; $display("FAIL modes_%0d got acc=%0d cnt=%0d ovf=%0b want %0d/1/0", i, o.acc, o.cnt, o.ovf, want[i]); end
                o = obs1.pop_front();
                checks++; if (o.acc != want[i]) begin failures++; $display("FAIL modes20_%0d got %0d want %0d", i, o.acc, want[i]); end
            end
        end
        model_clear();
    endtask

    task automatic test_saturation();
        bit ok;
        res_t o;
        for (int i = 0; i < 8; i++) beat_q.push_back(mk(32'h8080_8080, 32'h8080_8080, 1'b1, i == 7));
        beat_q.push_back(mk(32'h0101_0101, 32'h0101_0101, 1'b1, 1'b1));
        bubble_pct = 20;
        drain(200, ok);
        bubble_pct = 0;
        checks++; if (!ok || obs0.size() != 2 || obs1.size() != 2)
            begin failures++; $display("FAIL sat_count got %0d/%0d want 2", obs0.size(), obs1.size()); end
        else begin
            o = obs1.pop_front();
            checks++; if (o.acc != 524287 || o.ovf != 1'b1 || o.cnt != 8)
                begin failures++; $display("FAIL sat20 got acc=%0d ovf=%0b cnt=%0d want 524287/1/8", o.acc, o.ovf, o.cnt); end
            o = obs1.pop_front();
            checks++; if (o.acc != 4 || o.ovf != 1'b0 || o.cnt != 1)
                begin failures++; $display("FAIL sat20_next got acc=%0d ovf=%0b cnt=%0d want 4/0/1", o.acc, o.ovf, o.cnt); end
            o = obs0.pop_front();
            checks++; if (o.acc != 524288 || o.ovf != 1'b0 || o.cnt != 8)
                begin failures++; $display("FAIL sat32 got acc=%0d ovf=%0b cnt=%0d want 524288/0/8", o.acc, o.ovf, o.cnt); end
        end
        model_clear();
    endtask

    task automatic test_back_to_back();
        bubble_pct = 0; out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) beat_q.push_back(mk(32'h0101_0101, {4{8'(i)}}, 1'b1, 1'b1));
        repeat (3) tick();
        for (int i = 1; i <= 3; i++) begin
            checks++; if (out_valid !== 1'b1 || acc_out !== 32'(4 * i) || cnt_out !== 8'd1)
                begin failures++; $display("FAIL b2b_%0d got valid=%0b acc=%0d want 1/%0d", i, out_valid, acc_out, 4 * i); end
            checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_%0d got %0b want 1", i, in_ready); end
            tick();
        end
        repeat (4) tick();
        model_clear();
    endtask

    task automatic test_backpressure();
        bit ok;
        res_t o, e;
        logic [AW0-1:0] snap_acc;
        int n = 0;
        out_ready = 1'b0; bubble_pct = 0;
        beat_q.push_back(mk($urandom, $urandom, 1'b1, 1'b1));
        for (int i = 0; i < 4; i++) beat_q.push_back(mk($urandom, $urandom, 1'($urandom), i == 3));
        while (out_valid !== 1'b1 && n < 10) begin tick(); n++; end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_timeout out_valid got %0b want 1", out_valid); end
        snap_acc = acc_out;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || acc_out !== snap_acc || cnt_out !== 8'd1)
                begin failures++; $display("FAIL bp_hold_%0d got rdy=%0b vld=%0b acc=%0d want 0/1/%0d", i, in_ready, out_valid, acc_out, snap_acc); end
        end
        drain(100, ok);
        checks++; if (!ok || obs0.size() != 2 || exp0.size() != 2)
            begin failures++; $display("FAIL bp_count got %0d want 2", obs0.size()); end
        else begin
            for (int i = 0; i < 2; i++) begin
                o = obs0.pop_front(); e = exp0.pop_front();
                checks++; if (o.acc != e.acc || o.ovf != e.ovf || o.cnt != e.cnt)
                    begin failures++; $display("FAIL bp_res_%0d got %0d/%0b/%0d want %0d/%0b/%0d", i, o.acc, o.ovf, o.cnt, e.acc, e.ovf, e.cnt); end
            end
        end
        model_clear();
    endtask

    task automatic test_random();
        res_t o, e;
        logic [AW0-1:0] s_acc;
        logic [CNT_W-1:0] s_cnt;
        logic s_ovf;
        bit stalled, ok;
        int n = 0;
        int len;
        for (int p = 0; p < 30; p++) begin
            len = (p == 10) ? 260 : int'($urandom_range(1, 5));
            for (int i = 0; i < len; i++) begin
                if (p == 10) beat_q.push_back(mk(32'h8080_8080, 32'h8080_8080, 1'b1, i == len - 1));
                else beat_q.push_back(mk($urandom, $urandom, 1'($urandom), i == len - 1));
            end
        end
        bubble_pct = 20;
        while (beat_q.size() > 0 && n < 5000) begin
            out_ready = ($urandom_range(99) < 70);
            stalled = out_valid && !out_ready;
            s_acc = acc_out; s_cnt = cnt_out; s_ovf = ovf;
            tick();
            n++;
            if (stalled) begin
                checks++; if (out_valid !== 1'b1 || acc_out !== s_acc || cnt_out !== s_cnt || ovf !== s_ovf)
                    begin failures++; $display("FAIL rnd_hold got vld=%0b acc=%0d want 1/%0d", out_valid, acc_out, s_acc); end
            end
        end
        drain(100, ok);
        bubble_pct = 0;
        checks++; if (!ok || obs0.size() != 30 || obs1.size() != 30 || exp0.size() != 30)
            begin failures++; $display("FAIL rnd_count got %0d/%0d want 30", obs0.size(), obs1.size()); end
        else begin
            for (int i = 0; i < 30; i++) begin
                o = obs0.pop_front(); e = exp0.pop_front();
                checks++; if (o.acc != e.acc || o.ovf != e.ovf || o.cnt != e.cnt)
                    begin failures++; $display("FAIL rnd_%0d got %0d/%0b/%0d want %0d/%0b/%0d", i, o.acc, o.ovf, o.cnt, e.acc, e.ovf, e.cnt); end
                o = obs1.pop_front(); e = exp1.pop_front();
                checks++; if (o.acc != e.acc || o.ovf != e.ovf || o.cnt != e.cnt)
                    begin failures++; $display("FAIL rnd20_%0d got %0d/%0b/%0d want %0d/%0b/%0d", i, o.acc, o.ovf, o.cnt, e.acc, e.ovf, e.cnt); end
            end
        end
        model_clear();
    endtask

    task automatic test_reset_mid_packet();
        bit ok;
        res_t o;
        out_ready = 1'b0; bubble_pct = 0;
        beat_q.push_back(mk(32'h0101_0101, 32'h0101_0101, 1'b1, 1'b1));
        beat_q.push_back(mk(32'h0505_0505, 32'h0707_0707, 1'b1, 1'b0));
        beat_q.push_back(mk(32'h0505_0505, 32'h0707_0707, 1'b1, 1'b0));
        repeat (6) tick();
        checks++; if (out_valid !== 1'b1 || acc_out !== 32'd4 || in_ready !== 1'b0)
            begin failures++; $display("FAIL rstm_pre got vld=%0b acc=%0d rdy=%0b want 1/4/0", out_valid, acc_out, in_ready); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || acc_out !== 32'd0 || cnt_out !== 8'd0 || ovf !== 1'b0 || in_ready !== 1'b1)
            begin failures++; $display("FAIL rstm_clear got vld=%0b acc=%0d cnt=%0d ovf=%0b rdy=%0b want 0/0/0/0/1", out_valid, acc_out, cnt_out, ovf, in_ready); end
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        beat_q.push_back(mk(32'h0101_0101, 32'h0303_0303, 1'b1, 1'b1));
        drain(50, ok);
        checks++; if (!ok || obs0.size() != 1 || obs1.size() != 1)
            begin failures++; $display("FAIL rstm_count got %0d want 1", obs0.size()); end
        else begin
            o = obs0.pop_front();
            checks++; if (o.acc != 12 || o.cnt != 1 || o.ovf != 1'b0)
                begin failures++; $display("FAIL rstm_result got acc=%0d cnt=%0d ovf=%0b want 12/1/0", o.acc, o.cnt, o.ovf); end
        end
        model_clear();
    endtask

    initial begin
        test_reset();
        test_basic_latency();
        test_operand_modes();
        test_saturation();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_mid_packet();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_mac_pipe.md
ALU_MAC_PIPE -- requirements
Module: alu_mac_pipe

Interface
REQ-001 SHALL have parameter K, default 4, meaning number of multiply lanes (K >= 1, power of two).
REQ-002 SHALL have parameter DW, default 8, meaning operand width per lane.
REQ-003 SHALL have parameter ACC_W, default 32, meaning accumulator/result width; ACC_W >= 2*DW+1+log2(K).
REQ-004 SHALL have parameter CNT_W, default 8, meaning beat-counter width.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 in_valid  input  1  input beat valid.
REQ-008 in_ready  output  1  block can accept a beat.
REQ-009 matrix_in  input  DW*K  K packed operands, lane 0 in MSBs.
REQ-010 vector_in  input  DW*K  K packed operands, lane 0 in MSBs.
REQ-011 sgn  input  1  per beat: 1 = signed operands, 0 = unsigned.
REQ-012 in_last  input  1  final beat of a packet.
REQ-013 out_valid  output  1  result valid.
REQ-014 out_ready  input  1  downstream accepts result.
REQ-015 acc_out  output  ACC_W  signed dot-product result of packet.
REQ-016 ovf  output  1  result saturated at least once in packet.
REQ-017 cnt_out  output  CNT_W  beats in packet, saturating at 2^CNT_W-1.

Function
REQ-018 Beat accepted at a rising edge where in_valid && in_ready.
REQ-019 stall = out_valid && !out_ready; in_ready = !stall; all pipeline stages hold while stall.
REQ-020 Stage 1 (edge of acceptance): register K lane products, each a 2*DW+1 bit signed value (operands sign- or zero-extended per sgn), plus sgn-independent last and valid tags.
REQ-021 Stage 2 (next edge): register signed sum of the K products (adder tree), width 2*DW+1+log2(K), with tags.
REQ-022 Stage 3 (next edge): acc = sat(acc + sum) to ACC_W signed range; beat counter increments, saturating.
REQ-023 Saturation: result > 2^(ACC_W-1)-1 clamps to max, < -2^(ACC_W-1) clamps to min, and sets sticky packet overflow.
REQ-024 On stage-3 update of a last-tagged beat: acc_out, ovf, cnt_out load the final values, out_valid = 1, internal accumulator, counter and sticky overflow clear to 0 for the next packet.
REQ-025 Latency: last beat accepted at edge E0 -> out_valid high after edge E0+2, absent stalls.
REQ-026 out_valid, acc_out, ovf, cnt_out SHALL hold stable while out_valid && !out_ready.
REQ-027 Result handshake at edge with out_valid && out_ready; out_valid drops unless a new last beat completes stage 3 at that same edge, in which case new result loads and out_valid stays 1.
REQ-028 in_ready SHALL be 1 in the cycle out_ready is high, allowing back-to-back acceptance; throughput one beat per cycle without backpressure.
REQ-029 Single-beat packets (in_last on first beat) SHALL be supported; consecutive packets need no idle cycles.
REQ-030 Bubbles (in_valid low) SHALL pass through without affecting accumulator or counter.
REQ-031 sgn MAY differ beat to beat; each beat's products use its own sgn.

Reset
REQ-032 rst_n low SHALL immediately clear all pipeline valid tags, accumulator, counter, sticky overflow, out_valid, acc_out, ovf, cnt_out to 0; in_ready = 1 during and after reset.
REQ-033 Reset mid-packet SHALL discard the partial packet; first beat after release starts a new packet.

Verification
REQ-034 K=4, sgn=1, all matrix bytes 8'h01, vector bytes 8'h02, 3 beats, last on third -> acc_out=24, cnt_out=3, ovf=0, out_valid two edges after last acceptance.
REQ-035 sgn=1, all bytes 8'h80 both operands, 1 beat -> acc_out=65536; same bytes sgn=0 -> 4*16384=65536; bytes 8'hFF sgn=0 -> 260100, sgn=1 -> 4.
REQ-036 ACC_W=20, sgn=1, bytes 8'h80, 8 beats -> acc_out=524287, ovf=1, cnt_out=8; next packet of 1 beat 8'h01*8'h01 -> acc_out=4, ovf=0.
REQ-037 Result pending with out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0, outputs stable, no beat lost; release -> subsequent packet result correct.
REQ-038 Back-to-back single-beat packets with out_ready=1 and in_valid=1 every cycle -> one result per cycle, values 4,8,12 for vector bytes 1,2,3 and matrix bytes 1.
REQ-039 rst_n pulsed low after 2 beats of a 3-beat packet -> all outputs 0 at once; 1-beat packet afterwards yields only its own sum, cnt_out=1.
